// File: rtl/uart_rx_stream.sv
// uart_rx_stream
//   8N1 UART receiver feeding a small byte FIFO with a valid/ready output.
//   The RX line is double-flopped, oversampled by OVERSAMPLE ticks per bit,
//   and each good byte is pushed into the FIFO at the stop-bit sample.
//   Framing (stop bit low) and overrun (byte lost to a full FIFO) are sticky.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous, active-low reset
//   i_rx         asynchronous serial line, idle high
//   o_data       FIFO head byte, 0 when empty
//   o_valid      FIFO non-empty
//   i_ready      consumer accepts the head byte
//   i_clr_err    clears o_frame_err and o_overrun
//   o_frame_err  sticky: stop bit sampled low
//   o_overrun    sticky: byte dropped because the FIFO was full
//   o_busy       receiver FSM not idle
module uart_rx_stream #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    input  logic       i_clr_err,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam int unsigned DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [DIV_W-1:0]  DIV_M1  = DIV_W'(DIV - 1);
    localparam logic [TCNT_W-1:0] HALF_M1 = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] FULL_M1 = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FIFO_DEPTH);

    generate
        if (DIV < 1 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
            FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
            $error("uart_rx_stream: illegal parameters (DIV>=1, OVERSAMPLE even >=4, FIFO_DEPTH pow2 >=2)");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Oversample tick divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic             w_div_clr;

    assign w_tick = (r_div == DIV_M1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_div_clr || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t            r_state, w_state_nxt;
    logic [TCNT_W-1:0] r_tcnt,  w_tcnt_nxt;
    logic [2:0]        r_bidx,  w_bidx_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              w_push;
    logic              w_frame_set;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_tcnt  <= '0;
            r_bidx  <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_bidx  <= w_bidx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_bidx_nxt  = r_bidx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_frame_set = 1'b0;
        w_div_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_tcnt_nxt  = '0;
                    // Realign the tick phase to the detected start edge.
                    w_div_clr   = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_tcnt == HALF_M1) begin
                        // Mid start bit: a high line means the edge was a glitch.
                        if (r_rx_s) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_DATA;
                            w_tcnt_nxt  = '0;
                            w_bidx_nxt  = '0;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_tcnt == FULL_M1) begin
                        w_tcnt_nxt  = '0;
                        w_shift_nxt = {r_rx_s, r_shift[7:1]};
                        if (r_bidx == 3'd7) begin
                            w_state_nxt = S_STOP;
                        end else begin
                            w_bidx_nxt = r_bidx + 3'd1;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_tcnt == FULL_M1) begin
                        w_tcnt_nxt = '0;
                        if (r_rx_s) begin
                            w_push      = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_frame_set = 1'b1;
                            w_state_nxt = S_BREAK;
                        end
                    end else begin
                        w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                    end
                end
            end
            S_BREAK: begin
                // Hold here until the line recovers so a long break reports once.
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_busy = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_pop;
    logic             w_wr;
    logic             w_ovr_set;

    assign o_valid   = (r_count != '0);
    assign w_full    = (r_count == CNT_MAX);
    assign w_pop     = o_valid & i_ready;
    // A pop in the same clk frees the slot, so a full FIFO can still accept.
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovr_set = w_push & w_full & ~w_pop;
    assign o_data    = o_valid ? r_mem[r_rptr] : '0;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags (set wins over clear)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (w_frame_set) begin
                o_frame_err <= 1'b1;
            end else if (i_clr_err) begin
                o_frame_err <= 1'b0;
            end
            if (w_ovr_set) begin
                o_overrun <= 1'b1;
            end else if (i_clr_err) begin
                o_overrun <= 1'b0;
            end
        end
    end

endmodule
